// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - oversampled SPI slave with valid/ready TX and RX holding registers
module spi_slave_sync #(
  parameter int               WIDTH       = 8,
  parameter bit               CPOL        = 1'b0,
  parameter bit               CPHA        = 1'b0,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] TX_IDLE     = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             ce0,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overrun,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ce0_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   ce0_d;
  logic                   sclk_s;
  logic                   ce0_s;
  logic                   mosi_s;
  logic                   leading;
  logic                   trailing;
  logic                   sample_edge;
  logic                   drive_edge;
  logic                   ce0_fall;
  logic                   ce0_rise;
  logic                   active;
  logic                   abort;
  logic                   word_load;
  logic [WIDTH-1:0]       tx_hold;
  logic                   tx_full;
  logic [WIDTH-1:0]       tx_shift;
  logic [WIDTH-1:0]       rx_shift;
  logic [CW-1:0]          bit_cnt;

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign ce0_s       = ce0_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign leading     = (sclk_s != CPOL) && (sclk_d == CPOL);
  assign trailing    = (sclk_s == CPOL) && (sclk_d != CPOL);
  assign sample_edge = CPHA ? trailing : leading;
  assign drive_edge  = CPHA ? leading : trailing;
  assign ce0_fall    = !ce0_s && ce0_d;
  assign ce0_rise    = ce0_s && !ce0_d;
  assign active      = (state == ST_ACTIVE);
  assign abort       = active && ce0_rise;

  // CPHA=0 preloads the first bit on select and reloads after each full word;
  // CPHA=1 loads on the opening drive edge of every word. A drive edge seen
  // with the bit count at zero is exactly a word boundary in both modes.
  assign word_load = (!CPHA && !active && ce0_fall) ||
                     (active && !ce0_rise && drive_edge && (bit_cnt == '0));

  assign tx_ready = !tx_full;
  assign busy     = active;
  assign miso_oe  = active;
  assign miso     = active && tx_shift[WIDTH-1];

  // Oversample the async pins and keep one delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      ce0_sync  <= '1;
      mosi_sync <= '0;
      sclk_d    <= CPOL;
      ce0_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ce0_sync  <= {ce0_sync[SYNC_STAGES-2:0], ce0};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      ce0_d     <= ce0_s;
    end
  end

  // Select state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Select state follows the synchronised chip enable
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (ce0_fall) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (ce0_rise) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Holding registers, shift registers, bit count and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_hold     <= '0;
      tx_full     <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      // A handshake in a load cycle refills the holding register for the next word
      if (tx_valid && !tx_full) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end else if (word_load) begin
        tx_full <= 1'b0;
      end
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (abort) begin
        tx_shift <= '0;
        rx_shift <= '0;
        bit_cnt  <= '0;
      end else begin
        if (word_load) begin
          tx_shift    <= tx_full ? tx_hold : TX_IDLE;
          tx_underrun <= !tx_full;
        end else if (active && drive_edge) begin
          tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
        end
        if (active && sample_edge) begin
          rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
          bit_cnt  <= bit_cnt + 1'b1;
        end else if (bit_cnt == CNT_FULL) begin
          bit_cnt <= '0;
          if (!rx_valid || rx_ready) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
          end else begin
            rx_overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb/tb_spi_slave_sync.sv - self-checking bench for spi_slave_sync in all four SPI modes
module tb_spi_slave_sync;
  localparam int          W       = 8;
  localparam int          HALF    = 6;
  localparam int          SYNC    = 2;
  localparam logic [W-1:0] TX_IDLE_EXP = 8'h00;

  logic         clk;
  logic         rst;
  logic         sclk_a [4];
  logic         mosi_a [4];
  logic         ce0_a [4];
  logic         miso_a [4];
  logic         miso_oe_a [4];
  logic         tx_ready_a [4];
  logic         tx_valid_a [4];
  logic         rx_valid_a [4];
  logic         rx_overrun_a [4];
  logic         tx_underrun_a [4];
  logic         busy_a [4];
  logic [W-1:0] rx_data_a [4];
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         rx_ready;
  logic [1:0]   sel;

  logic         miso_m, miso_oe_m, tx_ready_m, rx_valid_m, rx_overrun_m, tx_underrun_m, busy_m;
  logic [W-1:0] rx_data_m;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int rise_cyc = -1;
  int n_under = 0;
  int n_over = 0;
  bit rxv_prev = 0;
  bit rdy_prev = 0;
  bit oe_seen = 0;

  logic [W-1:0] txq [$];
  logic [W-1:0] rxq [$];
  logic [W-1:0] misoq [$];
  logic [W-1:0] tx_w [8];
  logic [W-1:0] mosi_w [8];
  logic [W-1:0] exp_miso [8];
  int           exp_under;
  int           exp_over;
  int           exp_nrx;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign tx_valid_a[g] = tx_valid && (sel == 2'(g));
    spi_slave_sync #(
      .WIDTH(W), .CPOL((g / 2) != 0), .CPHA((g % 2) != 0), .SYNC_STAGES(SYNC), .TX_IDLE(TX_IDLE_EXP)
    ) u_dut (
      .clk(clk), .reset(rst), .sclk(sclk_a[g]), .mosi(mosi_a[g]), .ce0(ce0_a[g]),
      .miso(miso_a[g]), .miso_oe(miso_oe_a[g]), .tx_data(tx_data), .tx_valid(tx_valid_a[g]),
      .tx_ready(tx_ready_a[g]), .rx_data(rx_data_a[g]), .rx_valid(rx_valid_a[g]),
      .rx_ready(rx_ready), .rx_overrun(rx_overrun_a[g]), .tx_underrun(tx_underrun_a[g]),
      .busy(busy_a[g])
    );
  end

  assign miso_m        = miso_a[sel];
  assign miso_oe_m     = miso_oe_a[sel];
  assign tx_ready_m    = tx_ready_a[sel];
  assign rx_valid_m    = rx_valid_a[sel];
  assign rx_overrun_m  = rx_overrun_a[sel];
  assign tx_underrun_m = tx_underrun_a[sel];
  assign busy_m        = busy_a[sel];
  assign rx_data_m     = rx_data_a[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Fabric side: TX feeder from txq, RX consumer into rxq, pulse counters
  always @(negedge clk) begin
    if (rx_valid_m && rx_ready) rxq.push_back(rx_data_m);
    if (rx_valid_m && !rxv_prev && rise_cyc < 0) rise_cyc = cyc;
    rxv_prev = rx_valid_m;
    if (tx_underrun_m) n_under++;
    if (rx_overrun_m) n_over++;
    if (rst) begin
      tx_valid = 1'b0;
      rdy_prev = 1'b0;
    end else begin
      if (tx_valid && rdy_prev) void'(txq.pop_front());
      tx_valid = (txq.size() > 0);
      if (tx_valid) tx_data = txq[0];
      rdy_prev = tx_ready_m;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: loads = words (+1 trailing reload when CPHA=0); supplied words go out in order
  function automatic void model(input int nw, input int k, input bit rdy, input bit cpha);
    int loads;
    loads = nw + (cpha ? 0 : 1);
    for (int i = 0; i < nw; i++) exp_miso[i] = (i < k) ? tx_w[i] : TX_IDLE_EXP;
    exp_under = (loads > k) ? loads - k : 0;
    exp_nrx   = rdy ? nw : 0;
    exp_over  = rdy ? 0 : ((nw > 0) ? nw - 1 : 0);
  endfunction

  // SPI master for the selected instance; stop_after >= 0 deselects after that many bits
  task automatic master_xfer(input int nw, input int stop_after);
    bit cpol, cpha, stop;
    int bits;
    logic [W-1:0] word_in;
    cpol = sel[1];
    cpha = sel[0];
    bits = 0;
    stop = 0;
    oe_seen = 1;
    ce0_a[sel] = 1'b0;
    wait_clk(HALF);
    for (int w = 0; w < nw && !stop; w++) begin
      word_in = '0;
      for (int b = W - 1; b >= 0; b--) begin
        if (bits == stop_after) begin
          stop = 1;
          break;
        end
        if (cpha) sclk_a[sel] = ~cpol;
        mosi_a[sel] = mosi_w[w][b];
        wait_clk(HALF);
        word_in = {word_in[W-2:0], miso_m};
        if (!miso_oe_m) oe_seen = 0;
        last_cyc = cyc;
        sclk_a[sel] = cpha ? cpol : ~cpol;
        wait_clk(HALF);
        if (!cpha) sclk_a[sel] = cpol;
        bits++;
      end
      if (!stop) misoq.push_back(word_in);
    end
    if (!cpha && !stop) wait_clk(HALF);
    ce0_a[sel] = 1'b1;
    sclk_a[sel] = cpol;
    wait_clk(8);
  endtask

  task automatic run_xfer(input int nw, input int k, input bit rdy, input int stop_after);
    rxq.delete();
    misoq.delete();
    n_under = 0;
    n_over = 0;
    rise_cyc = -1;
    rx_ready = rdy;
    for (int i = 0; i < k; i++) txq.push_back(tx_w[i]);
    wait_clk(6);
    master_xfer(nw, stop_after);
    wait_clk(6);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (miso_a[i] !== 1'b0) begin errors++; $display("FAIL reset_miso[%0d] got %b exp 0", i, miso_a[i]); end
      checks++; if (miso_oe_a[i] !== 1'b0) begin errors++; $display("FAIL reset_oe[%0d] got %b exp 0", i, miso_oe_a[i]); end
      checks++; if (tx_ready_a[i] !== 1'b1) begin errors++; $display("FAIL reset_tx_ready[%0d] got %b exp 1", i, tx_ready_a[i]); end
      checks++; if (rx_valid_a[i] !== 1'b0) begin errors++; $display("FAIL reset_rx_valid[%0d] got %b exp 0", i, rx_valid_a[i]); end
      checks++; if (rx_data_a[i] !== 8'h00) begin errors++; $display("FAIL reset_rx_data[%0d] got %h exp 00", i, rx_data_a[i]); end
      checks++; if (busy_a[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b exp 0", i, busy_a[i]); end
      checks++; if ({rx_overrun_a[i], tx_underrun_a[i]} !== 2'b00) begin errors++; $display("FAIL reset_pulses[%0d] got %b%b exp 00", i, rx_overrun_a[i], tx_underrun_a[i]); end
    end
  endtask

  task automatic test_modes();
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: sel = 2'd0;
        1: sel = 2'd3;
        2: sel = 2'd1;
        3: sel = 2'd2;
        default: sel = 2'(c - 4);
      endcase
      tx_w[0]   = (c == 0) ? 8'h3C : (c == 1) ? 8'h81 : 8'($urandom);
      mosi_w[0] = (c == 0) ? 8'hA5 : (c == 1) ? 8'h5A : 8'($urandom);
      run_xfer(1, 1, 1'b1, -1);
      model(1, 1, 1'b1, sel[0]);
      checks++;
      if (misoq.size() != 1) begin errors++; $display("FAIL mode%0d_miso_words got %0d exp 1", sel, misoq.size()); end
      else begin
        checks++;
        if (misoq[0] !== exp_miso[0]) begin errors++; $display("FAIL mode%0d_miso got %h exp %h", sel, misoq[0], exp_miso[0]); end
      end
      checks++;
      if (rxq.size() != exp_nrx) begin errors++; $display("FAIL mode%0d_rx_count got %0d exp %0d", sel, rxq.size(), exp_nrx); end
      else begin
        checks++;
        if (rxq[0] !== mosi_w[0]) begin errors++; $display("FAIL mode%0d_rx_data got %h exp %h", sel, rxq[0], mosi_w[0]); end
      end
      checks++;
      if (n_under != exp_under || n_over != exp_over) begin
        errors++; $display("FAIL mode%0d_pulses got under=%0d over=%0d exp under=%0d over=%0d", sel, n_under, n_over, exp_under, exp_over);
      end
      checks++;
      if (rise_cyc - last_cyc != SYNC + 2) begin errors++; $display("FAIL mode%0d_latency got %0d exp %0d", sel, rise_cyc - last_cyc, SYNC + 2); end
      checks++;
      if (oe_seen !== 1'b1 || miso_oe_m !== 1'b0 || miso_m !== 1'b0) begin
        errors++; $display("FAIL mode%0d_oe got during=%b after=%b miso=%b exp 1 0 0", sel, oe_seen, miso_oe_m, miso_m);
      end
    end
  endtask

  task automatic test_burst();
    for (int c = 0; c < 2; c++) begin
      int nw;
      sel = (c == 0) ? 2'd3 : 2'd0;
      nw = (c == 0) ? 3 : 4;
      for (int i = 0; i < nw; i++) begin
        tx_w[i]   = (c == 0) ? 8'(8'h11 * (i + 1)) : 8'($urandom);
        mosi_w[i] = 8'($urandom);
      end
      run_xfer(nw, nw, 1'b1, -1);
      model(nw, nw, 1'b1, sel[0]);
      checks++;
      if (misoq.size() != nw || rxq.size() != exp_nrx) begin
        errors++; $display("FAIL burst%0d_counts got miso=%0d rx=%0d exp %0d %0d", c, misoq.size(), rxq.size(), nw, exp_nrx);
      end else begin
        for (int i = 0; i < nw; i++) begin
          checks++;
          if (misoq[i] !== exp_miso[i]) begin errors++; $display("FAIL burst%0d_miso[%0d] got %h exp %h", c, i, misoq[i], exp_miso[i]); end
          checks++;
          if (rxq[i] !== mosi_w[i]) begin errors++; $display("FAIL burst%0d_rx[%0d] got %h exp %h", c, i, rxq[i], mosi_w[i]); end
        end
      end
      checks++;
      if (n_under != exp_under || n_over != exp_over) begin
        errors++; $display("FAIL burst%0d_pulses got under=%0d over=%0d exp under=%0d over=%0d", c, n_under, n_over, exp_under, exp_over);
      end
    end
  endtask

  task automatic test_underrun();
    sel = 2'd3;
    tx_w[0] = 8'h77;
    mosi_w[0] = 8'($urandom);
    mosi_w[1] = 8'($urandom);
    run_xfer(2, 1, 1'b1, -1);
    model(2, 1, 1'b1, 1'b1);
    checks++;
    if (misoq.size() != 2) begin errors++; $display("FAIL underrun_words got %0d exp 2", misoq.size()); end
    else begin
      checks++;
      if (misoq[0] !== exp_miso[0] || misoq[1] !== exp_miso[1]) begin
        errors++; $display("FAIL underrun_miso got %h %h exp %h %h", misoq[0], misoq[1], exp_miso[0], exp_miso[1]);
      end
    end
    checks++;
    if (n_under != exp_under) begin errors++; $display("FAIL underrun_pulses got %0d exp %0d", n_under, exp_under); end
  endtask

  task automatic test_overrun();
    sel = 2'd0;
    mosi_w[0] = 8'h01;
    mosi_w[1] = 8'h02;
    run_xfer(2, 0, 1'b0, -1);
    model(2, 0, 1'b0, 1'b0);
    checks++;
    if (rx_valid_m !== 1'b1 || rx_data_m !== 8'h01) begin
      errors++; $display("FAIL overrun_hold got valid=%b data=%h exp 1 01", rx_valid_m, rx_data_m);
    end
    checks++;
    if (n_over != exp_over) begin errors++; $display("FAIL overrun_pulses got %0d exp %0d", n_over, exp_over); end
    checks++;
    if (n_under != exp_under) begin errors++; $display("FAIL overrun_underruns got %0d exp %0d", n_under, exp_under); end
    rx_ready = 1'b1;
    wait_clk(4);
    checks++;
    if (rxq.size() != 1 || rx_valid_m !== 1'b0) begin
      errors++; $display("FAIL overrun_drain got words=%0d valid=%b exp 1 0", rxq.size(), rx_valid_m);
    end else begin
      checks++;
      if (rxq[0] !== 8'h01) begin errors++; $display("FAIL overrun_word got %h exp 01", rxq[0]); end
    end
  endtask

  task automatic test_abort();
    sel = 2'd0;
    tx_w[0] = 8'($urandom);
    mosi_w[0] = 8'($urandom);
    run_xfer(1, 1, 1'b1, 5);
    checks++;
    if (rise_cyc != -1 || rxq.size() != 0 || n_over != 0) begin
      errors++; $display("FAIL abort_rx got rise=%0d words=%0d over=%0d exp -1 0 0", rise_cyc, rxq.size(), n_over);
    end
    checks++;
    if (busy_m !== 1'b0 || miso_oe_m !== 1'b0 || miso_m !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b oe=%b miso=%b exp 0 0 0", busy_m, miso_oe_m, miso_m);
    end
    tx_w[0] = 8'($urandom);
    mosi_w[0] = 8'($urandom);
    run_xfer(1, 1, 1'b1, -1);
    model(1, 1, 1'b1, 1'b0);
    checks++;
    if (misoq.size() != 1 || rxq.size() != 1) begin
      errors++; $display("FAIL abort_next_counts got miso=%0d rx=%0d exp 1 1", misoq.size(), rxq.size());
    end else begin
      checks++;
      if (misoq[0] !== exp_miso[0] || rxq[0] !== mosi_w[0]) begin
        errors++; $display("FAIL abort_next_data got miso=%h rx=%h exp %h %h", misoq[0], rxq[0], exp_miso[0], mosi_w[0]);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    sel = 2'd2;
    tx_w[0] = 8'($urandom);
    tx_w[1] = 8'($urandom);
    txq.push_back(tx_w[0]);
    txq.push_back(tx_w[1]);
    wait_clk(6);
    ce0_a[sel] = 1'b0;
    wait_clk(HALF);
    for (int b = 0; b < 3; b++) begin
      mosi_a[sel] = 1'($urandom);
      wait_clk(HALF);
      sclk_a[sel] = 1'b0;
      wait_clk(HALF);
      sclk_a[sel] = 1'b1;
    end
    sclk_a[sel] = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    txq.delete();
    #1;
    checks++;
    if (busy_m !== 1'b0 || miso_oe_m !== 1'b0 || miso_m !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle got busy=%b oe=%b miso=%b exp 0 0 0", busy_m, miso_oe_m, miso_m);
    end
    checks++;
    if (tx_ready_m !== 1'b1 || rx_valid_m !== 1'b0 || rx_data_m !== 8'h00) begin
      errors++; $display("FAIL rst_mid_regs got ready=%b valid=%b data=%h exp 1 0 00", tx_ready_m, rx_valid_m, rx_data_m);
    end
    ce0_a[sel] = 1'b1;
    sclk_a[sel] = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(6);
    checks++;
    if (busy_m !== 1'b0) begin errors++; $display("FAIL rst_release_busy got %b exp 0", busy_m); end
    tx_w[0] = 8'($urandom);
    mosi_w[0] = 8'($urandom);
    run_xfer(1, 1, 1'b1, -1);
    model(1, 1, 1'b1, 1'b0);
    checks++;
    if (misoq.size() != 1 || rxq.size() != 1) begin
      errors++; $display("FAIL rst_next_counts got miso=%0d rx=%0d exp 1 1", misoq.size(), rxq.size());
    end else begin
      checks++;
      if (misoq[0] !== exp_miso[0] || rxq[0] !== mosi_w[0]) begin
        errors++; $display("FAIL rst_next_data got miso=%h rx=%h exp %h %h", misoq[0], rxq[0], exp_miso[0], mosi_w[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sel = 2'd0;
    tx_valid = 1'b0;
    tx_data = '0;
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sclk_a[i] = (i / 2) != 0;
      mosi_a[i] = 1'b0;
      ce0_a[i] = 1'b1;
    end
    wait_clk(4);
    test_reset();
    rst = 1'b0;
    wait_clk(4);
    test_modes();
    test_burst();
    test_underrun();
    test_overrun();
    test_abort();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout after %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

endmodule
